// File: rtl/audio_pkg.sv
// Shared audio-chain parameters and types for the sigma-delta loopback decoder.
package audio_pkg;

  localparam int unsigned MSBI_DFLT       = 7;
  localparam int unsigned DECIM_LOG2_DFLT = 8;
  localparam int unsigned W_DFLT          = 2 * DECIM_LOG2_DFLT + 1;

  typedef logic [MSBI_DFLT:0] sample_t;

  localparam sample_t FULL_SCALE = sample_t'((1 << (MSBI_DFLT + 1)) - 1);

  // CIC start-up: the first two comb results are transients and are dropped.
  typedef enum logic [1:0] {
    WARM_0   = 2'd0,
    WARM_1   = 2'd1,
    WARM_RUN = 2'd2
  } warm_state_e;

endpackage

// File: rtl/sigma_delta_decoder_if.sv
// Decoded-sample output channel: one-entry valid/ready register plus sticky overrun.
interface sigma_delta_decoder_if #(
  parameter int unsigned MSBI = audio_pkg::MSBI_DFLT
);

  logic [MSBI:0] sample;
  logic          sample_valid;
  logic          sample_ready;
  logic          overrun;

  modport master (
    output sample,
    output sample_valid,
    output overrun,
    input  sample_ready
  );

  modport slave (
    input  sample,
    input  sample_valid,
    input  overrun,
    output sample_ready
  );

endinterface

// File: rtl/cic2_integrator.sv
// Two cascaded modulo-2^W integrators and the decimation counter of a 2nd-order CIC.
module cic2_integrator
  import audio_pkg::*;
#(
  parameter int unsigned DECIM_LOG2 = DECIM_LOG2_DFLT
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  din_i,
  output logic [2*DECIM_LOG2:0] i2_o,
  output logic                  tick_o
);

  localparam int unsigned W = 2 * DECIM_LOG2 + 1;
  localparam int unsigned R = 1 << DECIM_LOG2;
  localparam logic [DECIM_LOG2-1:0] TICK_PRE = DECIM_LOG2'(R - 2);

  logic [W-1:0]          i1_q;
  logic [W-1:0]          i2_q;
  logic [DECIM_LOG2-1:0] dcnt_q;
  logic                  tick_q;

  // tick_q is pre-decoded one cycle early so it is high exactly while dcnt_q == R-1.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      i1_q   <= '0;
      i2_q   <= '0;
      dcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      i1_q   <= i1_q + W'(din_i);
      i2_q   <= i2_q + i1_q;
      dcnt_q <= dcnt_q + DECIM_LOG2'(1);
      tick_q <= (dcnt_q == TICK_PRE);
    end
  end

  assign i2_o   = i2_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/sigma_delta_decoder.sv
// Sigma-delta bitstream to PCM: CIC2 decimator, scaling/saturation, warm-up and output handshake.
module sigma_delta_decoder
  import audio_pkg::*;
#(
  parameter int unsigned MSBI       = MSBI_DFLT,
  parameter int unsigned DECIM_LOG2 = DECIM_LOG2_DFLT
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  din,
  sigma_delta_decoder_if.master out_if
);

  localparam int unsigned W     = 2 * DECIM_LOG2 + 1;
  localparam int unsigned SHIFT = 2 * DECIM_LOG2 - (MSBI + 1);
  localparam int unsigned SW    = W - SHIFT;

  logic [W-1:0] i2;
  logic         tick;

  cic2_integrator #(
    .DECIM_LOG2 (DECIM_LOG2)
  ) u_integ (
    .clk     (clk),
    .n_reset (n_reset),
    .din_i   (din),
    .i2_o    (i2),
    .tick_o  (tick)
  );

  logic [W-1:0] i2_dly_q;
  logic [W-1:0] c1_q;
  logic [W-1:0] c1_dly_q;
  logic         comb2_en_q;

  // Comb 1 runs on the tick, comb 2 on the following cycle.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      i2_dly_q   <= '0;
      c1_q       <= '0;
      c1_dly_q   <= '0;
      comb2_en_q <= 1'b0;
    end else begin
      comb2_en_q <= tick;
      if (tick) begin
        c1_q     <= i2 - i2_dly_q;
        i2_dly_q <= i2;
      end
      if (comb2_en_q) begin
        c1_dly_q <= c1_q;
      end
    end
  end

  logic [W-1:0]  c2_c;
  logic [SW-1:0] scaled_c;
  logic [MSBI:0] sat_c;

  assign c2_c     = c1_q - c1_dly_q;
  assign scaled_c = SW'(c2_c >> SHIFT);
  assign sat_c    = scaled_c[SW-1] ? {(MSBI+1){1'b1}} : scaled_c[MSBI:0];

  warm_state_e   state_q, state_d;
  logic [MSBI:0] sample_q, sample_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;
  logic          emit_c;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= WARM_0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Warm-up sequencing and the one-entry output register.
  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    emit_c    = 1'b0;

    if (comb2_en_q) begin
      case (state_q)
        WARM_0:  state_d = WARM_1;
        WARM_1:  state_d = WARM_RUN;
        default: emit_c  = 1'b1;
      endcase
    end

    if (emit_c) begin
      sample_d = sat_c;
      valid_d  = 1'b1;
      if (valid_q && !out_if.sample_ready) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_if.sample_ready) begin
      valid_d = 1'b0;
    end
  end

  assign out_if.sample       = sample_q;
  assign out_if.sample_valid = valid_q;
  assign out_if.overrun      = overrun_q;

endmodule

// File: tb/tb_sigma_delta_decoder.sv
// Randomized bench for sigma_delta_decoder against a closed-form CIC2 reference model.
module tb_sigma_delta_decoder;
  import audio_pkg::*;

  localparam int unsigned R     = 1 << DECIM_LOG2_DFLT;
  localparam int unsigned SHIFT = 2 * DECIM_LOG2_DFLT - (MSBI_DFLT + 1);
  localparam longint      FS    = (longint'(1) << (MSBI_DFLT + 1)) - 1;
  localparam longint      MASK  = (longint'(1) << W_DFLT) - 1;
  localparam int          HMAX  = 4096;

  logic clk     = 1'b0;
  logic n_reset = 1'b0;
  logic din     = 1'b0;

  sigma_delta_decoder_if #(.MSBI(MSBI_DFLT)) sd_if ();

  sigma_delta_decoder #(
    .MSBI       (MSBI_DFLT),
    .DECIM_LOG2 (DECIM_LOG2_DFLT)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .din     (din),
    .out_if  (sd_if.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference state: bit history since reset release and the expected output register.
  bit     hist [HMAX];
  int     cyc;
  bit     exp_valid;
  bit     exp_overrun;
  longint exp_sample;
  bit     prev_ready;
  int     first_valid;
  int     mod_acc;

  // Second integrator value during cycle t, written as a weighted sum of past input bits.
  function automatic longint i2_at(input int t);
    longint acc = 0;
    for (int m = 0; m <= t - 2; m++) acc += longint'(t - 1 - m) * longint'(hist[m]);
    return acc;
  endfunction

  // Second difference of the integrated stream across three decimation boundaries.
  function automatic longint model_sample(input int n);
    int     t = n * int'(R) - 1;
    longint c2, s;
    c2 = (i2_at(t) - 2 * i2_at(t - int'(R)) + i2_at(t - 2 * int'(R))) & MASK;
    s  = c2 >> SHIFT;
    return (s > FS) ? FS : s;
  endfunction

  task automatic model_reset();
    cyc         = 0;
    exp_valid   = 1'b0;
    exp_overrun = 1'b0;
    exp_sample  = 0;
    prev_ready  = 1'b0;
    first_valid = -1;
    mod_acc     = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    n_reset = 1'b0;
    din     = 1'b0;
    sd_if.sample_ready = 1'b0;
    @(negedge clk);
    check_eq("rst_valid",   sd_if.sample_valid, 0);
    check_eq("rst_overrun", sd_if.overrun, 0);
    check_eq("rst_sample",  sd_if.sample, 0);
    n_reset = 1'b1;
    model_reset();
  endtask

  // dmode: 0 zero, 1 one, 2 alt 1,0, 3 1,0,0,0, 4 modulator DACin=64, 5 random density
  // rmode: 0 ready=1, 1 random, 2 ready only on emission cycles, 3 held low until 5R+10
  task automatic run_cycles(input int ncyc, input int dmode, input int rmode, input int dens);
    int  e;
    bit  d, rdy;
    for (int k = 0; k < ncyc; k++) begin
      if (cyc > 0) begin
        e = cyc - 1;
        if (e % int'(R) == 0 && e / int'(R) >= 3) begin
          if (exp_valid && !prev_ready) exp_overrun = 1'b1;
          exp_valid  = 1'b1;
          exp_sample = model_sample(e / int'(R));
        end else if (exp_valid && prev_ready) begin
          exp_valid = 1'b0;
        end
      end
      check_eq("valid",   sd_if.sample_valid, exp_valid);
      check_eq("overrun", sd_if.overrun, exp_overrun);
      if (exp_valid) check_eq("sample", sd_if.sample, exp_sample);
      if (sd_if.sample_valid && first_valid < 0) first_valid = cyc;

      case (dmode)
        0: d = 1'b0;
        1: d = 1'b1;
        2: d = (cyc % 2 == 0);
        3: d = (cyc % 4 == 0);
        4: begin
          mod_acc += 64;
          d = (mod_acc >= 128);
          if (d) mod_acc -= 128;
        end
        default: d = ($urandom_range(0, 99) < dens);
      endcase
      case (rmode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 3) != 0);
        2: rdy = (cyc % int'(R) == 0);
        default: rdy = (cyc >= 5 * int'(R) + 10);
      endcase
      din = d;
      sd_if.sample_ready = rdy;
      hist[cyc]  = d;
      prev_ready = rdy;
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    sd_if.sample_ready = 1'b0;
    model_reset();

    apply_reset();
    run_cycles(8 * R, 1, 0, 0);
    check_eq("first_valid_const1", first_valid, 3 * R + 1);
    check_eq("const1_saturated", sd_if.sample, 255);

    apply_reset();
    run_cycles(6 * R, 0, 1, 0);
    check_eq("const0_no_overrun", sd_if.overrun, 0);

    apply_reset();
    run_cycles(6 * R, 2, 0, 0);
    check_eq("alt10_value", sd_if.sample, 128);

    apply_reset();
    run_cycles(6 * R, 3, 0, 0);
    check_eq("p1000_value", sd_if.sample, 64);

    apply_reset();
    run_cycles(6 * R, 4, 1, 0);
    check_eq("modulator_in_range", (sd_if.sample >= 126 && sd_if.sample <= 130), 1);

    apply_reset();
    run_cycles(6 * R, 5, 3, $urandom_range(10, 90));
    check_eq("hold_overrun_sticky", sd_if.overrun, 1);
    check_eq("hold_valid_cleared",  sd_if.sample_valid, 0);

    apply_reset();
    run_cycles(6 * R, 5, 2, $urandom_range(10, 90));
    check_eq("coincident_valid",      sd_if.sample_valid, 1);
    check_eq("coincident_no_overrun", sd_if.overrun, 0);

    // Asynchronous reset asserted mid-cycle while a sample is pending.
    apply_reset();
    run_cycles(4 * R + 100, 5, 3, 70);
    @(posedge clk);
    #2 n_reset = 1'b0;
    #1;
    check_eq("async_rst_valid",   sd_if.sample_valid, 0);
    check_eq("async_rst_overrun", sd_if.overrun, 0);
    check_eq("async_rst_sample",  sd_if.sample, 0);
    @(negedge clk);
    n_reset = 1'b1;
    model_reset();
    run_cycles(4 * R, 1, 0, 0);
    check_eq("first_valid_after_rst", first_valid, 3 * R + 1);

    apply_reset();
    run_cycles(10 * R, 5, 1, $urandom_range(0, 100));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sigma_delta_decoder.md
# sigma_delta_decoder

Decodes a 1-bit sigma-delta bitstream, such as the note-generator speaker output, into unsigned PCM samples. It uses a second-order CIC decimator with power-of-two decimation, output scaling and saturation. Samples leave through a one-entry valid/ready output register with a sticky overrun flag. The block is the loopback and measurement path for the melody/sine-wave audio chain: it turns `speaker`-style bitstreams back into sample values that benches or on-chip monitors can check.

## Interface
- `MSBI`, 7: output sample MSB index; sample width is `MSBI+1`.
- `DECIM_LOG2`, 8: log2 of the decimation ratio, R = 2^`DECIM_LOG2`. Constraint: `DECIM_LOG2 >= MSBI+1`.

- `clk`  in  1  system clock. Also the bitstream bit clock.
- `n_reset`  in  1  asynchronous, active-low reset.
- `din`  in  1  sigma-delta bit, sampled every `clk`. 1 counts as +1, 0 counts as 0.
- `sample`  out  `MSBI+1`  decoded unsigned sample.
- `sample_valid`  out  1  `sample` holds an unconsumed value.
- `sample_ready`  in  1  consumer accepts `sample` this cycle.
- `overrun`  out  1  sticky: a sample was overwritten before it was consumed.

## Operation
- Internal width is W = 2·`DECIM_LOG2`+1. All integrator and comb arithmetic is modulo 2^W. Wrap-around is intended and must not be saturated.
- Every cycle the two integrators update: `i1 <= i1 + din`, `i2 <= i2 + i1`, where the `i2` update uses the old `i1`.
- Decimation counter `dcnt` counts 0..R-1 and then wraps. The cycle with `dcnt == R-1` is a tick.
- On a tick, comb stage 1 registers `c1 <= i2 - i2_d` and `i2_d <= i2`, using pre-update `i2`.
- On the cycle after a tick, comb stage 2 computes `c2 = c1 - c1_d` and registers `c1_d <= c1`.
- Scaling: `s = c2 >> (2·DECIM_LOG2 - (MSBI+1))`. If `s > 2^(MSBI+1)-1`, `sample` is 2^(MSBI+1)-1; otherwise `sample` is `s`.
- Warm-up: a 2-bit counter suppresses the first two comb results after reset, because they are CIC transients. Results are emitted from the third one onward.
- Steady state: if the pattern repeats with a period dividing R and has p ones per R cycles, the output is exactly `p·R >> (2·DECIM_LOG2-(MSBI+1))`, saturated. With the defaults this is `min(p,255)`.
- Output register:
  - An emitted result loads `sample` and sets `sample_valid`.
  - When `sample_valid && sample_ready` and no new result arrives the same cycle, `sample_valid` clears.
  - Simultaneous accept and new result: the old sample counts as consumed, the new one loads, and `sample_valid` stays 1. `overrun` is not set.
  - New result while `sample_valid && !sample_ready`: the new sample overwrites the old one and `overrun` sets.
  - `overrun` clears only on reset.

## Timing
- Reset values: all state is 0. `sample` = 0, `sample_valid` = 0, `overrun` = 0, `dcnt` = 0, warm-up count = 0.
- Reset asserted mid-operation clears everything immediately (asynchronous reset). Warm-up restarts after release.
- Latency: with tick in cycle T, `sample`/`sample_valid` update at the clock edge ending cycle T+1 and are visible in cycle T+2.
- First valid sample after reset release: in cycle 3R+1, counting the first post-reset cycle as 0.
- Samples are emitted every R cycles. The consumer has R-1 cycles of slack before an overrun occurs.
- `sample_ready` is ignored while `sample_valid` = 0.
- `din` is registered directly into `i1`. No combinational path exists from any input to any output.

## Structure
- Shared package `audio_pkg`:
  - `MSBI` default
  - `DECIM_LOG2` default
  - derived W
  - sample typedef `logic [MSBI:0]`
  - full-scale constant 2^(MSBI+1)-1
- One sub-module, `cic2_integrator`: the two integrators plus the decimation counter. It outputs `i2` and `tick`.
- Comb stages, scaling/saturation, warm-up and the output handshake stay in the top level.

## Test plan
- `din` constant 1, `sample_ready` held 1:
  - first `sample_valid` in cycle 3R+1 (769 with defaults);
  - `sample` = 255 (saturated);
  - thereafter one sample every 256 cycles.
- `din` constant 0: every emitted `sample` = 0 and `overrun` stays 0.
- `din` alternating 1,0: `sample` = 128. With pattern 1,0,0,0: `sample` = 64.
- `din` from the codebase sigma-delta modulator driven with `DACin` = 64: `sample` within 128±2, since the modulator's ones density is `DACin`/128.
- `sample_ready` held 0 across two emissions:
  - `overrun` sets on the second emission;
  - `sample` shows the second value;
  - raising `sample_ready` clears `sample_valid` the next cycle, and `overrun` stays 1.
- Accept coincident with a new emission: `sample_valid` stays 1 and `overrun` stays 0.
- `n_reset` pulsed low mid-stream: all outputs go to 0 immediately, and the next valid sample appears in cycle 3R+1 after release.
